// File: rtl/stream_split_using_double_buffers_if.sv
// Handshake bundle for the stream splitter: one packed-pair input stream and
// two half-width output streams (a = upper half, b = lower half).
interface stream_split_using_double_buffers_if #(parameter int width = 8);
   logic               in_valid;
   logic               in_ready;
   logic [2*width-1:0] in_data;
   logic               a_valid;
   logic               a_ready;
   logic [width-1:0]   a_data;
   logic               b_valid;
   logic               b_ready;
   logic [width-1:0]   b_data;

   modport master (
      output in_valid, in_data, a_ready, b_ready,
      input  in_ready, a_valid, a_data, b_valid, b_data
   );

   modport slave (
      input  in_valid, in_data, a_ready, b_ready,
      output in_ready, a_valid, a_data, b_valid, b_data
   );
endinterface

// File: rtl/stream_split_using_double_buffers.sv
// Eager fork of a packed operand-pair stream into two outputs, each decoupled
// by its own two-entry (main + skid) double buffer.

module stream_split_using_double_buffers_lane #(parameter int width = 8) (
   input  logic             clk,
   input  logic             rst_n,
   input  logic             push,
   input  logic [width-1:0] up_data,
   output logic             up_ready,
   output logic             dn_valid,
   input  logic             dn_ready,
   output logic [width-1:0] dn_data
);
   logic             main_valid, skid_valid;
   logic [width-1:0] main_data, skid_data;

   // Upstream ready is purely registered: a push only ever lands while skid is empty.
   assign up_ready = ~skid_valid;
   assign dn_valid = main_valid;
   assign dn_data  = main_data;

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         main_valid <= 1'b0;
         main_data  <= '0;
         skid_valid <= 1'b0;
         skid_data  <= '0;
      end else if (push) begin
         if (!main_valid || dn_ready) begin
            main_valid <= 1'b1;
            main_data  <= up_data;
         end else begin
            skid_valid <= 1'b1;
            skid_data  <= up_data;
         end
      end else if (main_valid && dn_ready) begin
         main_valid <= skid_valid;
         if (skid_valid) main_data <= skid_data;
         skid_valid <= 1'b0;
      end
   end
endmodule

module stream_split_using_double_buffers #(parameter int width = 8) (
   input  logic clk,
   input  logic rst_n,
   stream_split_using_double_buffers_if.slave io
);
   localparam int NUM_LANES = 2;  // lane 1 = a (upper half), lane 0 = b (lower half)

   logic [NUM_LANES-1:0][width-1:0] lane_in_data, lane_out_data;
   logic [NUM_LANES-1:0]            push, up_ready, done, dn_valid, dn_ready;
   logic                            in_ready;

   assign lane_in_data = io.in_data;
   assign dn_ready     = {io.a_ready, io.b_ready};

   // A side that already took the current word waits for the other one.
   assign push     = {NUM_LANES{io.in_valid}} & ~done & up_ready;
   assign in_ready = &(done | up_ready);

   assign io.in_ready = in_ready;
   assign io.a_valid  = dn_valid[1];
   assign io.a_data   = lane_out_data[1];
   assign io.b_valid  = dn_valid[0];
   assign io.b_data   = lane_out_data[0];

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n)                        done <= '0;
      else if (io.in_valid && in_ready)  done <= '0;
      else                               done <= done | push;
   end

   for (genvar l = 0; l < NUM_LANES; l++) begin : g_lane
      stream_split_using_double_buffers_lane #(.width(width)) u_lane (
         .clk      (clk),
         .rst_n    (rst_n),
         .push     (push[l]),
         .up_data  (lane_in_data[l]),
         .up_ready (up_ready[l]),
         .dn_valid (dn_valid[l]),
         .dn_ready (dn_ready[l]),
         .dn_data  (lane_out_data[l])
      );
   end
endmodule

// File: tb/tb_stream_split_using_double_buffers.sv
// Self-checking bench: scoreboard queues per output, table-driven streaming,
// directed stall/reset sequences and a randomized valid/ready soak.
module tb_stream_split_using_double_buffers;
   localparam int W = 8;

   logic clk = 1'b0;
   logic rst_n;
   always #5 clk = ~clk;

   stream_split_using_double_buffers_if #(.width(W)) io ();

   stream_split_using_double_buffers #(.width(W)) dut (
      .clk   (clk),
      .rst_n (rst_n),
      .io    (io)
   );

   typedef struct {
      logic [2*W-1:0] din;
      logic [W-1:0]   a_exp;
      logic [W-1:0]   b_exp;
   } vec_t;

   int checks = 0;
   int errors = 0;
   logic [W-1:0] qa[$];
   logic [W-1:0] qb[$];

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s: got %0h, expected %0h", name, act, exp);
      end
   endtask

   // Output transfers are decided by values stable around the negedge.
   always @(negedge clk) begin
      if (rst_n) begin
         if (io.a_valid && io.a_ready) begin
            if (qa.size() == 0) begin
               checks++; errors++;
               $display("FAIL a_unexpected: got word %0h, expected none", io.a_data);
            end else check("a_data", io.a_data, qa.pop_front());
         end
         if (io.b_valid && io.b_ready) begin
            if (qb.size() == 0) begin
               checks++; errors++;
               $display("FAIL b_unexpected: got word %0h, expected none", io.b_data);
            end else check("b_data", io.b_data, qb.pop_front());
         end
      end
   end

   task automatic offer_exp(input logic [2*W-1:0] d, input logic [W-1:0] ea, input logic [W-1:0] eb);
      qa.push_back(ea);
      qb.push_back(eb);
      io.in_valid = 1'b1;
      io.in_data  = d;
   endtask

   task automatic offer(input logic [2*W-1:0] d);
      offer_exp(d, d[2*W-1:W], d[W-1:0]);
   endtask

   task automatic wait_accept();
      int n = 0;
      forever begin
         @(negedge clk);
         if (io.in_ready) break;
         if (++n > 200) begin
            checks++; errors++;
            $display("FAIL accept_timeout: in_ready stuck at 0, expected 1");
            break;
         end
      end
      @(posedge clk); #1;
      io.in_valid = 1'b0;
   endtask

   task automatic send(input logic [2*W-1:0] d);
      offer(d);
      wait_accept();
   endtask

   task automatic drain(input string name);
      for (int n = 0; n < 500 && (qa.size() != 0 || qb.size() != 0); n++) @(negedge clk);
      check({name, "_drain_a"}, qa.size(), 0);
      check({name, "_drain_b"}, qb.size(), 0);
      @(posedge clk); #1;
   endtask

   task automatic check_idle(input string name);
      check({name, "_a_valid"}, io.a_valid, 0);
      check({name, "_b_valid"}, io.b_valid, 0);
      check({name, "_a_data"},  io.a_data, 0);
      check({name, "_b_data"},  io.b_data, 0);
      check({name, "_in_ready"}, io.in_ready, 1);
   endtask

   vec_t vt[3];
   int   offered;
   bit   acc;

   initial begin
      vt[0] = '{16'h0102, 8'h01, 8'h02};
      vt[1] = '{16'h0304, 8'h03, 8'h04};
      vt[2] = '{16'h0506, 8'h05, 8'h06};

      rst_n = 1'b0;
      io.in_valid = 1'b0; io.in_data = '0; io.a_ready = 1'b0; io.b_ready = 1'b0;
      @(negedge clk);
      check_idle("reset");
      @(negedge clk) rst_n = 1'b1;
      @(posedge clk); #1;

      // Reset mid-stream: both buffers full, third word pending.
      send(16'h5566);
      send(16'h7788);
      offer(16'h99AA);
      #2 rst_n = 1'b0;
      #1 check_idle("midrst");
      qa.delete(); qb.delete();
      io.in_valid = 1'b0;
      @(negedge clk);
      check_idle("inrst");
      @(negedge clk) rst_n = 1'b1;
      io.a_ready = 1'b1; io.b_ready = 1'b1;
      repeat (3) @(negedge clk);
      check_idle("postrst");
      @(posedge clk); #1;

      // Streaming, both consumers ready: no bubbles.
      for (int i = 0; i < 3; i++) begin
         offer_exp(vt[i].din, vt[i].a_exp, vt[i].b_exp);
         @(negedge clk);
         check("stream_in_ready", io.in_ready, 1);
         if (i > 0) begin
            check("stream_a_valid", io.a_valid, 1);
            check("stream_b_valid", io.b_valid, 1);
         end
         @(posedge clk); #1;
      end
      io.in_valid = 1'b0;
      @(negedge clk);
      check("stream_last_a_valid", io.a_valid, 1);
      check("stream_last_a_data", io.a_data, 8'h05);
      drain("stream");

      // Both stalled: two words accepted, third held.
      io.a_ready = 1'b0; io.b_ready = 1'b0;
      send(16'hA1B1);
      send(16'hA2B2);
      offer(16'hA3B3);
      @(negedge clk);
      check("stall_in_ready", io.in_ready, 0);
      repeat (3) @(negedge clk);
      check("stall_in_ready_hold", io.in_ready, 0);
      check("stall_a_hold", io.a_data, 8'hA1);
      check("stall_b_hold", io.b_data, 8'hB1);
      @(posedge clk); #1;
      io.a_ready = 1'b1; io.b_ready = 1'b1;
      wait_accept();
      drain("stall");

      // Only A stalled: B runs one word ahead, input holds on the third.
      io.a_ready = 1'b0; io.b_ready = 1'b1;
      send(16'h1011);
      send(16'h2021);
      offer(16'h3031);
      repeat (4) @(negedge clk);
      check("asym_in_ready", io.in_ready, 0);
      check("asym_b_got3", qb.size(), 0);
      check("asym_a_pending", qa.size(), 3);
      @(posedge clk); #1;
      io.a_ready = 1'b1;
      @(negedge clk);
      check("asym_resume_in_ready0", io.in_ready, 0);
      @(negedge clk);
      check("asym_resume_in_ready1", io.in_ready, 1);
      @(posedge clk); #1;
      io.in_valid = 1'b0;
      send(16'h4041);
      drain("asym");

      // Randomized soak on all three handshakes.
      offered = 0;
      for (int cyc = 0; cyc < 80000 && (offered < 10000 || io.in_valid); cyc++) begin
         @(negedge clk);
         acc = io.in_valid && io.in_ready;
         @(posedge clk); #1;
         io.a_ready = ($urandom_range(0, 3) != 0);
         io.b_ready = ($urandom_range(0, 3) != 0);
         if (acc) io.in_valid = 1'b0;
         if (!io.in_valid && offered < 10000 && $urandom_range(0, 3) != 0) begin
            offer(16'($urandom));
            offered++;
         end
      end
      check("rand_offered", offered, 10000);
      check("rand_in_valid_done", io.in_valid, 0);
      io.a_ready = 1'b1; io.b_ready = 1'b1;
      drain("rand");

      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end
endmodule

// File: doc/stream_split_using_double_buffers.md
# stream_split_using_double_buffers

Splits one valid/ready stream of packed operand pairs into two independent valid/ready streams, `a` and `b`. Each output is decoupled by its own two-entry double buffer, so one stalled consumer does not block the other until that buffer fills. This is the fork counterpart of the team's two-stream join (adder) and sits upstream of it, distributing operand pairs to independent consumers.

## Interface
- `width`, default 8, bit width of each output word; input word is `2*width`.
- `clk`  input  1  single clock, all state on rising edge.
- `rst_n`  input  1  asynchronous, active-low reset.
- `in_valid`  input  1  input word valid.
- `in_ready`  output  1  block accepts the input word this cycle.
- `in_data`  input  2*width  packed pair: `[2*width-1:width]` → `a`, `[width-1:0]` → `b`.
- `a_valid`  output  1  `a_data` valid.
- `a_ready`  input  1  consumer A accepts.
- `a_data`  output  width  upper half of the input word.
- `b_valid`  output  1  `b_data` valid.
- `b_ready`  input  1  consumer B accepts.
- `b_data`  output  width  lower half of the input word.

## Operation
- Transfer on any interface = `valid && ready` at a rising edge.
- Per-output double buffer (Dally–Harting): main register (drives output) plus skid register. `up_ready = ~skid_valid`, registered. A push while main is full and not draining goes to skid. When main drains, skid moves to main. Push and pop in the same cycle give full throughput.
- Eager fork between the input and the two buffers:
  - Flags `a_done`, `b_done` record which side has already taken the current input word.
  - `a_push = in_valid & ~a_done & a_up_ready`; `b_push` likewise.
  - `in_ready = (a_done | a_up_ready) & (b_done | b_up_ready)`. It depends only on registered state and has no combinational path from `in_valid`, `a_ready` or `b_ready`.
  - On an input transfer, both done flags clear. Otherwise a flag sets when its side pushes.
- Each input word is delivered exactly once to each output, in order. Words are never duplicated or dropped.
- Data is a pure bit split: no arithmetic, no sign handling.

## Timing
- Reset (asynchronous assert, synchronous release): all valid, skid and done flags are 0, `a_data`/`b_data` = 0, `a_valid`/`b_valid` = 0, `in_ready` = 1.
- Latency: input transfer at edge N gives `a_valid`/`b_valid` high after edge N (next cycle), if the main register is empty or draining.
- Throughput: one word per cycle when both consumers hold ready high.
- Both outputs stalled: 2 words are accepted, then `in_ready` falls the cycle after the 2nd transfer.
- Only A stalled, B ready: A stores 2 words. Word 3 is pushed to B (`b_done`=1) and held at the input with `in_ready`=0. B therefore receives words 1–3 and A receives words 1–2.
- When A resumes: first `a_ready` pop frees A's skid the next cycle. Word 3 is then pushed to A, `in_ready` returns to 1 and the done flags clear.
- Simultaneous push and pop in one buffer: main is replaced, skid is unchanged.
- `in_valid` dropping while a done flag is set is a protocol violation. Upstream holds valid and data until `in_ready`. Behaviour is undefined but must not corrupt the other buffer.
- Reset mid-stream discards all buffered words and done flags immediately. There are no spurious output valids after release.

## Test plan
- Reset: assert `rst_n`=0 mid-transfer → all valids 0, data 0, `in_ready`=1 during and after reset.
- Streaming: `in_data` 0x0102, 0x0304, 0x0506 on consecutive cycles, both readys 1 → `a` gives 0x01, 0x03, 0x05 and `b` gives 0x02, 0x04, 0x06, one cycle later, with no bubbles.
- Both stalled: readys 0, offer 0xA1B1, 0xA2B2, 0xA3B3 → only 2 accepted, `in_ready`=0. Raise readys → outputs A1/B1, A2/B2, A3/B3 in order.
- Asymmetric stall: `a_ready`=0, `b_ready`=1, offer 0x1011, 0x2021, 0x3031, 0x4041 → B sees 11, 21, 31 and input stalls on 0x3031. Release A → A sees 10, 20, 30, 40, B sees 41, with no loss or duplicate.
- Random valid/ready on all three ports for 10k words against a scoreboard → per-output order and content exact, `in_ready` never depends combinationally on `in_valid`.
